// File: rtl/csr_unit.sv
// Machine-mode CSR file with interrupt trap / mret redirect for a simple in-order core.
// Optional CSR_TIMER_EN adds the mtime/mtimecmp timer at 0x7C0/0x7C1.
module csr_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        valid,
  input  logic        csr_rd,
  input  logic        csr_wr,
  input  logic        is_mret,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  input  logic        ext_irq,
  input  logic        timer_irq,
  output logic [31:0] rdata,
  output logic        epc_taken,
  output logic [31:0] epc
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MTIME    = 12'h7C0;
  localparam logic [11:0] ADDR_MTIMECMP = 12'h7C1;

  state_t      r_state;
  logic        r_mie;
  logic        r_mpie;
  logic        r_mtie;
  logic        r_meie;
  logic [29:0] r_mtvec;
  logic [29:0] r_mepc;
  logic [31:0] r_mcause;
  logic        r_sync1;
  logic        r_sync2;
`ifdef CSR_TIMER_EN
  logic [31:0] r_mtime;
  logic [31:0] r_mtimecmp;
`endif

  logic [11:0] w_addr;
  logic        w_mtip;
  logic        w_meip;
  logic [31:0] w_mstatus;
  logic [31:0] w_mie;
  logic [31:0] w_mip;
  logic        w_run;
  logic        w_trap;
  logic        w_mret;
  logic        w_wr;

  assign w_addr = inst[31:20];
  assign w_meip = r_sync2;
`ifdef CSR_TIMER_EN
  assign w_mtip = timer_irq | (r_mtime >= r_mtimecmp);
`else
  assign w_mtip = timer_irq;
`endif

  assign w_mstatus = {24'b0, r_mpie, 3'b0, r_mie, 3'b0};
  assign w_mie     = {20'b0, r_meie, 3'b0, r_mtie, 7'b0};
  assign w_mip     = {20'b0, w_meip, 3'b0, w_mtip, 7'b0};

  // mret outranks a pending interrupt; the interrupt is re-evaluated after FLUSH.
  assign w_run  = (r_state == RUN);
  assign w_trap = w_run & valid & r_mie & (|(w_mip & w_mie)) & ~is_mret;
  assign w_mret = w_run & valid & is_mret;
  assign w_wr   = w_run & valid & csr_wr & ~w_trap;

  assign epc_taken = ~rst & (w_trap | w_mret);
  assign epc       = ~epc_taken ? 32'b0 :
                     w_trap     ? {r_mtvec, 2'b00} : {r_mepc, 2'b00};

  always_comb begin
    rdata = 32'b0;
    if (csr_rd & valid & ~rst) begin
      case (w_addr)
        ADDR_MSTATUS:  rdata = w_mstatus;
        ADDR_MIE:      rdata = w_mie;
        ADDR_MTVEC:    rdata = {r_mtvec, 2'b00};
        ADDR_MEPC:     rdata = {r_mepc, 2'b00};
        ADDR_MCAUSE:   rdata = r_mcause;
        ADDR_MIP:      rdata = w_mip;
`ifdef CSR_TIMER_EN
        ADDR_MTIME:    rdata = r_mtime;
        ADDR_MTIMECMP: rdata = r_mtimecmp;
`endif
        default:       rdata = 32'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RUN;
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_mtie     <= 1'b0;
      r_meie     <= 1'b0;
      r_mtvec    <= 30'b0;
      r_mepc     <= 30'b0;
      r_mcause   <= 32'b0;
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
`ifdef CSR_TIMER_EN
      r_mtime    <= 32'b0;
      r_mtimecmp <= 32'hFFFF_FFFF;
`endif
    end else begin
      r_sync1 <= ext_irq;
      r_sync2 <= r_sync1;
`ifdef CSR_TIMER_EN
      // A software load of mtime replaces that cycle's increment.
      if (w_wr && (w_addr == ADDR_MTIME)) r_mtime <= wdata;
      else                                r_mtime <= r_mtime + 32'd1;
      if (w_wr && (w_addr == ADDR_MTIMECMP)) r_mtimecmp <= wdata;
`endif
      case (r_state)
        RUN: begin
          if (w_trap) begin
            r_mepc   <= pc[31:2];
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
            r_mcause <= (w_meip & r_meie) ? 32'h8000_000B : 32'h8000_0007;
            r_state  <= FLUSH;
          end else begin
            if (w_wr) begin
              case (w_addr)
                ADDR_MSTATUS: begin
                  r_mie  <= wdata[3];
                  r_mpie <= wdata[7];
                end
                ADDR_MIE: begin
                  r_mtie <= wdata[7];
                  r_meie <= wdata[11];
                end
                ADDR_MTVEC:  r_mtvec  <= wdata[31:2];
                ADDR_MEPC:   r_mepc   <= wdata[31:2];
                ADDR_MCAUSE: r_mcause <= wdata;
                default: ;
              endcase
            end
            if (w_mret) begin
              r_mie   <= r_mpie;
              r_mpie  <= 1'b1;
              r_state <= FLUSH;
            end
          end
        end
        FLUSH:   r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

endmodule
